// File: rtl/axi4_frame_writer_pkg.sv
// Shared AXI constants, writer FSM states and a width helper for the frame writer.
package axi4_frame_writer_pkg;

  localparam logic [1:0] BURST_INCR       = 2'b01;
  localparam logic [1:0] RESP_OKAY        = 2'b00;
  localparam logic [3:0] CACHE_BUFFERABLE = 4'b0011;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} wr_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO; head is valid whenever empty is low.
module sync_fwft_fifo import axi4_frame_writer_pkg::*; #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head,
  output logic [clog2(DEPTH):0]   count,
  output logic                    full,
  output logic                    empty
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage carries no reset; only the pointers define contents
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axi4_frame_writer.sv
// Streams pixel beats into rotating frame buffers via AXI4 INCR write bursts,
// one burst outstanding, never crossing a 4 KB page.
module axi4_frame_writer import axi4_frame_writer_pkg::*; #(
  parameter int          DATA_W      = 64,
  parameter int          ADDR_W      = 32,
  parameter int          BURST_LEN   = 64,
  parameter int          FRAME_BEATS = 19200,
  parameter int          NUM_BUFS    = 3,
  parameter logic [31:0] BUF_STRIDE  = 32'h0010_0000,
  parameter int          FIFO_DEPTH  = 256
) (
  input  logic                clk_100Mhz,
  input  logic                rst,
  input  logic                enable,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [7:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic [3:0]          AWCACHE,
  output logic [2:0]          AWPROT,
  output logic [DATA_W-1:0]   WDATA,
  output logic                WVALID,
  input  logic                WREADY,
  output logic                WLAST,
  output logic [DATA_W/8-1:0] WSTRB,
  input  logic                BVALID,
  output logic                BREADY,
  input  logic [1:0]          BRESP,
  output logic                frame_done,
  output logic                frame_err,
  output logic [1:0]          done_buf,
  output logic [1:0]          wr_buf,
  output logic [15:0]         err_count,
  output logic                busy
);
  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = clog2(FIFO_DEPTH) + 1;
  localparam int POS_W = clog2(FRAME_BEATS + 1);
  localparam int LEN_W = 9;

  if (BURST_LEN * BYTES > 4096 || (4096 % (BURST_LEN * BYTES)) != 0) begin : g_bad_burst
    $error("burst size must evenly divide a 4 KB page");
  end
  if (BUF_STRIDE[11:0] != 12'h000) begin : g_bad_stride
    $error("BUF_STRIDE must be 4 KB aligned");
  end
  if (FIFO_DEPTH < 2 * BURST_LEN || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo
    $error("FIFO_DEPTH must be a power of two and at least 2*BURST_LEN");
  end

  wr_state_e          state;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full, fifo_empty;
  logic               in_active, in_fire, w_fire, bad_resp, last_burst;
  logic [POS_W-1:0]   in_pos, out_pos;
  logic [LEN_W-1:0]   cur_len, next_len, beat;
  logic [ADDR_W-1:0]  offset;
  logic [31:0]        remain;
  logic               err_flag;

  sync_fwft_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk(clk_100Mhz), .rst(rst),
    .push(in_fire), .push_data(s_data),
    .pop(w_fire), .head(WDATA),
    .count(fifo_count), .full(fifo_full), .empty(fifo_empty)
  );

  assign s_ready    = in_active && !fifo_full;
  assign in_fire    = s_valid && s_ready;
  assign AWVALID    = (state == ST_ADDR);
  assign WVALID     = (state == ST_DATA) && !fifo_empty;
  assign WLAST      = (state == ST_DATA) && (beat == cur_len - 1'b1);
  assign w_fire     = WVALID && WREADY;
  assign AWLEN      = 8'(cur_len - 1'b1);
  assign AWSIZE     = 3'(clog2(BYTES));
  assign AWBURST    = BURST_INCR;
  assign AWCACHE    = CACHE_BUFFERABLE;
  assign AWPROT     = 3'b000;
  assign WSTRB      = '1;
  assign BREADY     = 1'b1;
  assign busy       = (state != ST_IDLE) || !fifo_empty;
  assign remain     = 32'(FRAME_BEATS) - 32'(out_pos);
  assign next_len   = (remain >= 32'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(remain);
  assign bad_resp   = (BRESP != RESP_OKAY);
  assign last_burst = (32'(out_pos) + 32'(cur_len) == 32'(FRAME_BEATS));

  // Input only (re)arms at a frame boundary, so a dropped enable never truncates a frame.
  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      in_active <= 1'b0;
      in_pos    <= '0;
    end else if (in_fire) begin
      if (in_pos == POS_W'(FRAME_BEATS - 1)) begin
        in_pos    <= '0;
        in_active <= enable;
      end else begin
        in_pos <= in_pos + 1'b1;
      end
    end else if (!in_active && enable) begin
      in_active <= 1'b1;
    end
  end

  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      state      <= ST_IDLE;
      AWADDR     <= '0;
      cur_len    <= '0;
      beat       <= '0;
      out_pos    <= '0;
      offset     <= '0;
      wr_buf     <= 2'd0;
      done_buf   <= 2'(NUM_BUFS - 1);
      err_count  <= 16'd0;
      err_flag   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: if (fifo_count >= CNT_W'(next_len)) begin
          cur_len <= next_len;
          AWADDR  <= base_addr + ADDR_W'(32'(wr_buf) * BUF_STRIDE) + offset;
          state   <= ST_ADDR;
        end
        ST_ADDR: if (AWREADY) begin
          beat  <= '0;
          state <= ST_DATA;
        end
        ST_DATA: if (w_fire) begin
          beat <= beat + 1'b1;
          if (WLAST) state <= ST_RESP;
        end
        ST_RESP: if (BVALID) begin
          state <= ST_IDLE;
          if (bad_resp && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          if (last_burst) begin
            frame_done <= 1'b1;
            frame_err  <= err_flag || bad_resp;
            done_buf   <= wr_buf;
            wr_buf     <= (wr_buf == 2'(NUM_BUFS - 1)) ? 2'd0 : wr_buf + 2'd1;
            err_flag   <= 1'b0;
            offset     <= '0;
            out_pos    <= '0;
          end else begin
            err_flag <= err_flag || bad_resp;
            offset   <= offset + ADDR_W'(32'(cur_len) * 32'(BYTES));
            out_pos  <= out_pos + POS_W'(cur_len);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_frame_writer.sv
// Scoreboard bench for axi4_frame_writer: expected AW bursts, W data and frame
// completions are queued as stimulus is issued and popped as the DUT responds.
module tb_axi4_frame_writer;
  localparam int          DATA_W      = 64;
  localparam int          ADDR_W      = 32;
  localparam int          BURST_LEN   = 64;
  localparam int          FRAME_BEATS = 150;
  localparam int          NUM_BUFS    = 3;
  localparam int          FIFO_DEPTH  = 256;
  localparam logic [31:0] BUF_STRIDE  = 32'h0010_0000;
  localparam logic [31:0] BASE        = 32'h1000_0000;

  logic                clk_100Mhz = 1'b0;
  logic                rst = 1'b1, enable = 1'b0;
  logic [ADDR_W-1:0]   base_addr = BASE;
  logic [DATA_W-1:0]   s_data;
  logic                s_valid, s_ready;
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID, AWREADY;
  logic [7:0]          AWLEN;
  logic [2:0]          AWSIZE, AWPROT;
  logic [1:0]          AWBURST, BRESP, done_buf, wr_buf;
  logic [3:0]          AWCACHE;
  logic [DATA_W-1:0]   WDATA;
  logic                WVALID, WREADY, WLAST, BVALID, BREADY;
  logic [DATA_W/8-1:0] WSTRB;
  logic                frame_done, frame_err, busy;
  logic [15:0]         err_count;

  axi4_frame_writer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .FRAME_BEATS(FRAME_BEATS),
    .NUM_BUFS(NUM_BUFS), .BUF_STRIDE(BUF_STRIDE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_100Mhz(clk_100Mhz), .rst(rst), .enable(enable), .base_addr(base_addr),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .frame_done(frame_done), .frame_err(frame_err), .done_buf(done_buf), .wr_buf(wr_buf),
    .err_count(err_count), .busy(busy)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct packed { logic [1:0] buf_id; logic err; } fr_t;

  int errors = 0, checks = 0;
  aw_t aw_q[$];
  logic [DATA_W-1:0] data_q[$];
  fr_t fr_q[$];
  logic [1:0] bresp_q[$];

  int src_pct = 0, in_beats = 0, b_pend = 0, w_beat = 0, frames_seen = 0, aw_total = 0;
  bit stall_on = 0, in_hs = 0, aw_hs_s = 0, w_hs_s = 0;
  bit aw_open = 0, aw_wait = 0, w_wait = 0, fd_prev = 0;
  logic [7:0] cur_len_exp = 8'd0;
  logic [31:0] seq = 32'd0, aw_prev = 32'd0;
  logic [DATA_W-1:0] w_prev = '0;

  // pixel source: holds a beat until accepted, otherwise offers one with src_pct% probability
  initial begin
    s_valid = 1'b0;
    s_data  = '0;
    forever begin
      @(posedge clk_100Mhz); #1;
      if (in_hs) seq = seq + 32'd1;
      if (!s_valid || in_hs) begin
        s_valid = ($urandom_range(99) < src_pct);
        s_data  = {seq ^ 32'hA5C3_0000, seq};
      end
    end
  end

  // slave readiness: after each handshake optionally stall 0..5 cycles
  initial begin
    int aw_stall, w_stall;
    aw_stall = 0; w_stall = 0;
    AWREADY = 1'b1; WREADY = 1'b1;
    forever begin
      @(posedge clk_100Mhz); #1;
      if (aw_hs_s) aw_stall = stall_on ? int'($urandom_range(5)) : 0;
      else if (aw_stall > 0) aw_stall--;
      if (w_hs_s) w_stall = stall_on ? int'($urandom_range(5)) : 0;
      else if (w_stall > 0) w_stall--;
      AWREADY = (aw_stall == 0);
      WREADY  = (w_stall == 0);
    end
  end

  // write-response channel: one B per completed burst, response taken from bresp_q
  initial begin
    BVALID = 1'b0;
    BRESP  = 2'b00;
    forever begin
      @(posedge clk_100Mhz); #1;
      if (rst) begin
        b_pend = 0;
        BVALID = 1'b0;
      end else if (BVALID) begin
        BVALID = 1'b0;
      end else if (b_pend > 0) begin
        b_pend--;
        BVALID = 1'b1;
        BRESP  = 2'b00;
        if (bresp_q.size() > 0) BRESP = bresp_q.pop_front();
      end
    end
  end

  always @(negedge clk_100Mhz) begin : mon
    aw_t e;
    fr_t f;
    logic [DATA_W-1:0] d;
    logic [1:0] nb;
    if (rst) begin
      in_hs = 0; aw_hs_s = 0; w_hs_s = 0; aw_wait = 0; w_wait = 0;
      fd_prev = 0; w_beat = 0; aw_open = 0;
    end else begin
      in_hs = s_valid && s_ready;
      if (in_hs) begin data_q.push_back(s_data); in_beats++; end
      if (aw_wait) begin
        checks++;
        if (AWVALID !== 1'b1 || AWADDR !== aw_prev) begin
          errors++; $display("FAIL aw_stable got valid=%b addr=%h want valid=1 addr=%h", AWVALID, AWADDR, aw_prev);
        end
      end
      if (w_wait) begin
        checks++;
        if (WVALID !== 1'b1 || WDATA !== w_prev) begin
          errors++; $display("FAIL w_stable got valid=%b data=%h want valid=1 data=%h", WVALID, WDATA, w_prev);
        end
      end
      aw_wait = AWVALID && !AWREADY; aw_prev = AWADDR;
      w_wait  = WVALID && !WREADY;   w_prev  = WDATA;
      w_hs_s  = WVALID && WREADY;
      aw_hs_s = AWVALID && AWREADY;
      if (w_hs_s) begin
        checks++;
        if (!aw_open) begin errors++; $display("FAIL w_before_aw got beat without open burst want none"); end
        checks++;
        if (data_q.size() == 0) begin
          errors++; $display("FAIL wdata_extra got %h want no beat", WDATA);
        end else begin
          d = data_q.pop_front();
          if (WDATA !== d) begin errors++; $display("FAIL wdata got %h want %h", WDATA, d); end
        end
        checks++;
        if (WLAST !== (w_beat == int'(cur_len_exp))) begin
          errors++; $display("FAIL wlast beat=%0d got %b want %b", w_beat, WLAST, (w_beat == int'(cur_len_exp)));
        end
        if (WLAST) begin aw_open = 0; b_pend++; w_beat = 0; end
        else w_beat++;
      end
      if (aw_hs_s) begin
        aw_total++;
        checks++;
        if (aw_q.size() == 0) begin
          errors++; $display("FAIL aw_extra got addr=%h len=%0d want no burst", AWADDR, AWLEN);
        end else begin
          e = aw_q.pop_front();
          if (AWADDR !== e.addr || AWLEN !== e.len) begin
            errors++; $display("FAIL aw got addr=%h len=%0d want addr=%h len=%0d", AWADDR, AWLEN, e.addr, e.len);
          end
          cur_len_exp = e.len;
        end
        aw_open = 1; w_beat = 0;
      end
      if (frame_done) begin
        frames_seen++;
        checks++;
        if (fd_prev) begin errors++; $display("FAIL frame_done_pulse got 2-cycle pulse want 1"); end
        checks++;
        if (fr_q.size() == 0) begin
          errors++; $display("FAIL frame_extra got done_buf=%0d want no frame", done_buf);
        end else begin
          f  = fr_q.pop_front();
          nb = (f.buf_id == 2'(NUM_BUFS - 1)) ? 2'd0 : f.buf_id + 2'd1;
          if (done_buf !== f.buf_id || frame_err !== f.err || wr_buf !== nb) begin
            errors++; $display("FAIL frame got done_buf=%0d err=%b wr_buf=%0d want %0d %b %0d",
                               done_buf, frame_err, wr_buf, f.buf_id, f.err, nb);
          end
        end
      end
      fd_prev = frame_done;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_100Mhz);
  endtask

  // queue the bursts, B responses and completion one full frame into buffer b should produce
  task automatic expect_frame(input logic [1:0] b, input int bad_burst);
    int rem, off, k, l;
    rem = FRAME_BEATS; off = 0; k = 0;
    while (rem > 0) begin
      l = (rem < BURST_LEN) ? rem : BURST_LEN;
      aw_q.push_back('{addr: BASE + 32'(b) * BUF_STRIDE + 32'(off), len: 8'(l - 1)});
      bresp_q.push_back((k == bad_burst) ? 2'b10 : 2'b00);
      off += l * DATA_W / 8; rem -= l; k++;
    end
    fr_q.push_back('{buf_id: b, err: (bad_burst >= 0)});
  endtask

  task automatic wait_beats(input int n, input int budget);
    int t;
    t = 0;
    while (in_beats < n && t < budget) begin @(negedge clk_100Mhz); t++; end
    checks++;
    if (in_beats < n) begin errors++; $display("FAIL wait_beats got %0d want %0d", in_beats, n); end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t;
    t = 0;
    while (frames_seen < n && t < budget) begin @(negedge clk_100Mhz); t++; end
    checks++;
    if (frames_seen < n) begin errors++; $display("FAIL wait_frames got %0d want %0d", frames_seen, n); end
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0;
    cycles(3);
    @(negedge clk_100Mhz);
    checks++; if (s_ready !== 1'b0)    begin errors++; $display("FAIL rst_s_ready got %b want 0", s_ready); end
    checks++; if (AWVALID !== 1'b0)    begin errors++; $display("FAIL rst_awvalid got %b want 0", AWVALID); end
    checks++; if (WVALID !== 1'b0)     begin errors++; $display("FAIL rst_wvalid got %b want 0", WVALID); end
    checks++; if (WLAST !== 1'b0)      begin errors++; $display("FAIL rst_wlast got %b want 0", WLAST); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
    checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL rst_frame_err got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (wr_buf !== 2'd0)     begin errors++; $display("FAIL rst_wr_buf got %0d want 0", wr_buf); end
    checks++; if (done_buf !== 2'd2)   begin errors++; $display("FAIL rst_done_buf got %0d want 2", done_buf); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL rst_err_count got %0d want 0", err_count); end
    checks++; if (AWSIZE !== 3'd3 || AWBURST !== 2'b01 || AWCACHE !== 4'b0011 || AWPROT !== 3'd0) begin
      errors++; $display("FAIL aw_consts got size=%0d burst=%0d cache=%0d prot=%0d want 3 1 3 0", AWSIZE, AWBURST, AWCACHE, AWPROT);
    end
    checks++; if (WSTRB !== 8'hFF || BREADY !== 1'b1) begin
      errors++; $display("FAIL w_consts got strb=%h bready=%b want ff 1", WSTRB, BREADY);
    end
    @(posedge clk_100Mhz); #1 rst = 1'b0;
    cycles(3); @(negedge clk_100Mhz);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL idle_no_enable got s_ready=%b want 0", s_ready); end
  endtask

  // three back-to-back frames through all buffers, enable dropped at beat 70 of the third
  task automatic test_basic_frames;
    int start, aw_before;
    expect_frame(2'd0, -1); expect_frame(2'd1, -1); expect_frame(2'd2, -1);
    start = in_beats; src_pct = 100; stall_on = 0; enable = 1'b1;
    wait_beats(start + 2 * FRAME_BEATS + 70, 5000);
    enable = 1'b0;
    wait_frames(3, 5000);
    aw_before = aw_total;
    cycles(60); @(negedge clk_100Mhz);
    checks++; if (in_beats !== start + 3 * FRAME_BEATS) begin errors++; $display("FAIL basic_in_beats got %0d want %0d", in_beats - start, 3 * FRAME_BEATS); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL basic_s_ready got %b want 0", s_ready); end
    checks++; if (aw_total !== aw_before) begin errors++; $display("FAIL basic_no_aw got %0d want %0d", aw_total, aw_before); end
    checks++; if (wr_buf !== 2'd0 || done_buf !== 2'd2) begin errors++; $display("FAIL basic_bufs got wr=%0d done=%0d want 0 2", wr_buf, done_buf); end
    checks++; if (busy !== 1'b0 || aw_q.size() != 0) begin errors++; $display("FAIL basic_idle got busy=%b aw_left=%0d want 0 0", busy, aw_q.size()); end
  endtask

  // random stalls and 50% source; second burst of the first frame gets SLVERR
  task automatic test_stalls_errors;
    int start, f0;
    expect_frame(2'd0, 1); expect_frame(2'd1, -1);
    start = in_beats; f0 = frames_seen; src_pct = 50; stall_on = 1; enable = 1'b1;
    wait_beats(start + FRAME_BEATS + 70, 20000);
    enable = 1'b0;
    wait_frames(f0 + 2, 20000);
    stall_on = 0;
    cycles(30); @(negedge clk_100Mhz);
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL err_count got %0d want 1", err_count); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_err_clear got %b want 0", frame_err); end
    checks++; if (in_beats !== start + 2 * FRAME_BEATS) begin errors++; $display("FAIL stall_in_beats got %0d want %0d", in_beats - start, 2 * FRAME_BEATS); end
    checks++; if (wr_buf !== 2'd2 || busy !== 1'b0) begin errors++; $display("FAIL stall_end got wr=%0d busy=%b want 2 0", wr_buf, busy); end
  endtask

  // reset while beat 10 of a burst is on the bus, then a clean frame from base_addr
  task automatic test_reset_mid;
    int t, start, f0;
    expect_frame(2'd2, -1);
    src_pct = 100; enable = 1'b1; t = 0;
    while (!(w_beat == 10 && WVALID) && t < 2000) begin @(posedge clk_100Mhz); #2; t++; end
    checks++; if (!(w_beat == 10 && WVALID)) begin errors++; $display("FAIL reach_beat10 got beat=%0d want 10", w_beat); end
    rst = 1'b1;
    @(posedge clk_100Mhz); @(negedge clk_100Mhz);
    checks++; if (AWVALID !== 1'b0 || WVALID !== 1'b0) begin errors++; $display("FAIL midrst_valid got aw=%b w=%b want 0 0", AWVALID, WVALID); end
    checks++; if (wr_buf !== 2'd0 || err_count !== 16'd0) begin errors++; $display("FAIL midrst_regs got wr=%0d errc=%0d want 0 0", wr_buf, err_count); end
    checks++; if (busy !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL midrst_idle got busy=%b s_ready=%b want 0 0", busy, s_ready); end
    aw_q.delete(); data_q.delete(); fr_q.delete(); bresp_q.delete();
    @(posedge clk_100Mhz); #1 rst = 1'b0;
    expect_frame(2'd0, -1);
    start = in_beats; f0 = frames_seen;
    wait_beats(start + 70, 5000);
    enable = 1'b0;
    wait_frames(f0 + 1, 5000);
    cycles(40); @(negedge clk_100Mhz);
    checks++; if (in_beats !== start + FRAME_BEATS) begin errors++; $display("FAIL post_rst_beats got %0d want %0d", in_beats - start, FRAME_BEATS); end
    checks++; if (wr_buf !== 2'd1 || done_buf !== 2'd0) begin errors++; $display("FAIL post_rst_bufs got wr=%0d done=%0d want 1 0", wr_buf, done_buf); end
    checks++; if (aw_q.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL post_rst_idle got aw_left=%0d busy=%b want 0 0", aw_q.size(), busy); end
  endtask

  initial begin
    test_reset();
    test_basic_frames();
    test_stalls_errors();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
